kmp_lps_builder: RTL and testbench

- Upstream preprocessing stage for the KMP text search unit.
- On a start request it reads the search pattern from the pattern ROM and computes the KMP failure table (longest proper prefix-suffix, "LPS").
- It writes the table, one entry per cycle, into the LPS memory the search stage uses when it falls back on a mismatch.
- It asserts done so the top-level FSM may raise the search start (inicio).

---
 rtl/kmp_pkg.sv | 19 +
 rtl/kmp_pat_buffer.sv | 38 +++
 rtl/kmp_lps_builder.sv | 167 ++++++++++++++++
 tb/tb_kmp_lps_builder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/kmp_pkg.sv
// Shared types and defaults for the KMP search unit.
// Used by the LPS builder and the search stage.
package kmp_pkg;

    localparam int KMP_PAT_LEN = 4;
    localparam int KMP_AW      = 3;
    localparam int KMP_DW      = 8;

    typedef logic [KMP_DW-1:0] char_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_COMPUTE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/kmp_pat_buffer.sv
// Pattern character buffer: one load port, two combinational
// read ports (text index i and prefix length len).
module kmp_pat_buffer
    import kmp_pkg::*;
#(
    parameter int PAT_LEN = KMP_PAT_LEN,
    parameter int AW      = KMP_AW,
    parameter int DW      = KMP_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ld_en,
    input  logic [AW-1:0] i_ld_idx,
    input  logic [DW-1:0] i_ld_data,
    input  logic [AW-1:0] i_rd_a_idx,
    input  logic [AW-1:0] i_rd_b_idx,
    output logic [DW-1:0] o_rd_a_data,
    output logic [DW-1:0] o_rd_b_data
);

    localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

    logic [DW-1:0] r_mem [PAT_LEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PAT_LEN; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_ld_en) begin
            r_mem[IW'(i_ld_idx)] <= i_ld_data;
        end
    end

    assign o_rd_a_data = r_mem[IW'(i_rd_a_idx)];
    assign o_rd_b_data = r_mem[IW'(i_rd_b_idx)];

endmodule

// File: rtl/kmp_lps_builder.sv
// Loads the pattern from ROM and builds the KMP failure (LPS)
// table, writing one entry per advancing cycle.
module kmp_lps_builder
    import kmp_pkg::*;
#(
    parameter int PAT_LEN = KMP_PAT_LEN,
    parameter int AW      = KMP_AW,
    parameter int DW      = KMP_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] pat_addr,
    input  logic [DW-1:0] pat_data,
    output logic          lps_we,
    output logic [AW-1:0] lps_addr,
    output logic [AW-1:0] lps_wdata,
    output logic          busy,
    output logic          done
);

    localparam int              IW      = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [AW-1:0]   LAST_I  = AW'(PAT_LEN - 1);
    localparam logic [AW:0]     LD_LAST = (AW+1)'(PAT_LEN);

    state_t        r_state;
    logic [AW:0]   r_ld_cnt;
    logic [AW-1:0] r_pat_addr;
    logic [AW-1:0] r_i;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_lps_addr;
    logic [AW-1:0] r_lps_wdata;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_lps_sh [PAT_LEN];

    logic          w_ld_en;
    logic [AW-1:0] w_ld_idx;
    logic [DW-1:0] w_ch_i;
    logic [DW-1:0] w_ch_len;
    logic          w_eq;
    logic          w_adv;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_wdata;
    logic [AW-1:0] w_len_inc;
    logic [AW-1:0] w_fb_len;

    kmp_pat_buffer #(
        .PAT_LEN (PAT_LEN),
        .AW      (AW),
        .DW      (DW)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_ld_en     (w_ld_en),
        .i_ld_idx    (w_ld_idx),
        .i_ld_data   (pat_data),
        .i_rd_a_idx  (r_i),
        .i_rd_b_idx  (r_len),
        .o_rd_a_data (w_ch_i),
        .o_rd_b_data (w_ch_len)
    );

    // The write strobe is decided from the registered i/len of the
    // current cycle so each entry lands in the cycle that computes it.
    always_comb begin
        w_ld_en   = (r_state == ST_LOAD) && (r_ld_cnt != '0);
        w_ld_idx  = AW'(r_ld_cnt - 1'b1);
        w_eq      = (w_ch_i == w_ch_len);
        w_len_inc = r_len + 1'b1;
        w_adv     = w_eq || (r_len == '0);
        w_fb_len  = r_lps_sh[IW'(r_len - 1'b1)];
        w_we      = 1'b0;
        w_waddr   = r_lps_addr;
        w_wdata   = r_lps_wdata;
        if (r_state == ST_INIT) begin
            w_we    = 1'b1;
            w_waddr = '0;
            w_wdata = '0;
        end else if (r_state == ST_COMPUTE && w_adv) begin
            w_we    = 1'b1;
            w_waddr = r_i;
            w_wdata = w_eq ? w_len_inc : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ld_cnt    <= '0;
            r_pat_addr  <= '0;
            r_i         <= '0;
            r_len       <= '0;
            r_lps_addr  <= '0;
            r_lps_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int k = 0; k < PAT_LEN; k++) begin
                r_lps_sh[k] <= '0;
            end
        end else begin
            if (w_we) begin
                r_lps_addr  <= w_waddr;
                r_lps_wdata <= w_wdata;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_busy     <= 1'b1;
                        r_pat_addr <= '0;
                        r_ld_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (r_ld_cnt == LD_LAST) begin
                        r_state <= ST_INIT;
                    end else begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                        if ((r_ld_cnt + 1'b1) < LD_LAST) begin
                            r_pat_addr <= AW'(r_ld_cnt + 1'b1);
                        end
                    end
                end
                ST_INIT: begin
                    r_lps_sh[IW'(0)] <= '0;
                    r_i              <= AW'(1);
                    r_len            <= '0;
                    if (PAT_LEN > 1) begin
                        r_state <= ST_COMPUTE;
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (w_adv) begin
                        r_lps_sh[IW'(r_i)] <= w_wdata;
                        r_i                <= r_i + 1'b1;
                        r_len              <= w_eq ? w_len_inc : '0;
                        if (r_i == LAST_I) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_len <= w_fb_len;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pat_addr  = r_pat_addr;
    assign lps_we    = w_we;
    assign lps_addr  = w_waddr;
    assign lps_wdata = w_wdata;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_kmp_lps_builder.sv
// Directed bench for kmp_lps_builder: PAT_LEN=4 and PAT_LEN=1
// instances fed from small registered ROM models.
module tb_kmp_lps_builder;
    import kmp_pkg::*;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start0;
    logic          start1;
    logic          sel;
    logic [AW-1:0] pa0, pa1;
    char_t         pd0, pd1;
    logic          we0, we1;
    logic [AW-1:0] la0, la1, lw0, lw1;
    logic          busy0, busy1, done0, done1;

    logic          m_we, m_busy, m_done;
    logic [AW-1:0] m_addr, m_wdata;

    char_t rom0 [4];
    char_t rom1 [1];
    int    exp_lps [4];
    int    wa [8];
    int    wd [8];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        pd0 <= rom0[pa0[1:0]];
        pd1 <= rom1[0];
    end

    always_comb begin
        m_we    = sel ? we1   : we0;
        m_busy  = sel ? busy1 : busy0;
        m_done  = sel ? done1 : done0;
        m_addr  = sel ? la1   : la0;
        m_wdata = sel ? lw1   : lw0;
    end

    kmp_lps_builder #(.PAT_LEN(4), .AW(AW), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .pat_addr  (pa0),
        .pat_data  (pd0),
        .lps_we    (we0),
        .lps_addr  (la0),
        .lps_wdata (lw0),
        .busy      (busy0),
        .done      (done0)
    );

    kmp_lps_builder #(.PAT_LEN(1), .AW(AW), .DW(8)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .pat_addr  (pa1),
        .pat_data  (pd1),
        .lps_we    (we1),
        .lps_addr  (la1),
        .lps_wdata (lw1),
        .busy      (busy1),
        .done      (done1)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic set_pat(input char_t a, input char_t b,
                           input char_t c, input char_t d);
        rom0[0] = a;
        rom0[1] = b;
        rom0[2] = c;
        rom0[3] = d;
    endtask

    task automatic set_exp(input int a, input int b, input int c, input int d);
        exp_lps[0] = a;
        exp_lps[1] = b;
        exp_lps[2] = c;
        exp_lps[3] = d;
    endtask

    // Cycle 1 is the first cycle after the edge that accepts start.
    task automatic run_build(input string tag, input int n, input int exp_done,
                             input int exp_gaps, input int re1, input int re2);
        int cyc, nw, gaps, done_cyc, busy_low, extra;
        cyc = 0; nw = 0; gaps = 0; done_cyc = 0; busy_low = 0; extra = 0;
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        cyc = 1;
        while (done_cyc == 0 && cyc <= 40) begin
            if (!m_busy) busy_low++;
            if (m_we) begin
                if (nw < 8) begin
                    wa[nw] = int'(m_addr);
                    wd[nw] = int'(m_wdata);
                end
                nw++;
            end else if (nw > 0 && !m_done) begin
                gaps++;
            end
            if (m_done) done_cyc = cyc;
            if (done_cyc == 0) begin
                set_start(cyc == re1 || cyc == re2);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        set_start(1'b0);
        check({tag, " done_cycle"}, done_cyc, exp_done);
        check({tag, " writes"}, nw, n);
        for (int k = 0; k < n && k < 8; k++) begin
            check($sformatf("%s addr[%0d]", tag, k), wa[k], k);
            check($sformatf("%s lps[%0d]", tag, k), wd[k], exp_lps[k]);
        end
        check({tag, " no_write_cycles"}, gaps, exp_gaps);
        check({tag, " busy_low"}, busy_low, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            if (m_we || m_done || m_busy) extra++;
        end
        check({tag, " idle_after"}, extra, 0);
    endtask

    initial begin
        int nw;
        int guard;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        sel = 1'b0;
        set_pat("A", "A", "A", "A");
        rom1[0] = "Z";
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", int'(busy0), 0);
        check("rst done", int'(done0), 0);
        check("rst we", int'(we0), 0);
        check("rst pat_addr", int'(pa0), 0);
        check("rst lps_addr", int'(la0), 0);
        check("rst lps_wdata", int'(lw0), 0);
        check("rst pat_addr1", int'(pa1), 0);
        rst = 1'b0;

        set_exp(0, 1, 2, 3);
        run_build("AAAA", 4, 10, 0, 0, 0);

        set_pat("A", "B", "A", "B");
        set_exp(0, 0, 1, 2);
        run_build("ABAB", 4, 10, 0, 0, 0);

        set_pat("A", "A", "B", "A");
        set_exp(0, 1, 0, 1);
        run_build("AABA", 4, 11, 1, 0, 0);

        run_build("AABA_restart", 4, 11, 1, 3, 8);
        run_build("AABA_again", 4, 11, 1, 0, 0);

        set_pat("A", "A", "A", "A");
        set_exp(0, 1, 2, 3);
        nw = 0;
        guard = 0;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        while (nw < 2 && guard < 20) begin
            if (we0) nw++;
            if (nw < 2) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        check("rst_mid reached", nw, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid busy", int'(busy0), 0);
        check("rst_mid we", int'(we0), 0);
        check("rst_mid done", int'(done0), 0);
        check("rst_mid pat_addr", int'(pa0), 0);
        run_build("AAAA_after_rst", 4, 10, 0, 0, 0);

        sel = 1'b1;
        set_exp(0, 0, 0, 0);
        run_build("Z", 1, 4, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
